// File: rtl/execute_maskscan_pkg.sv
// execute_maskscan_pkg
// Shared definitions for the mask-scan decoder: FSM state encoding,
// the clz value reported for an all-zero input, and a SCAN_W legality
// helper used by the top level at elaboration time.
// Optional feature macro: EXECUTE_MASKSCAN_CLZ_EN (adds the clz constant).
package execute_maskscan_pkg;

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_SCAN = 2'd1,
    MS_DONE = 2'd2
  } ms_state_e;

`ifdef EXECUTE_MASKSCAN_CLZ_EN
  localparam logic [5:0] MS_ZERO_CLZ = 6'd32;
`endif

  // Only power-of-two slice widths that divide 32 evenly are supported.
  function automatic bit scan_w_legal(input int w);
    return (w == 1) || (w == 2) || (w == 4) || (w == 8);
  endfunction

endpackage

// File: rtl/execute_maskscan_slice.sv
// execute_maskscan_slice
// Combinational examiner for one SCAN_W-bit slice of the value being
// decoded. Each bit is compared with its neighbour above (run top) and
// below (run bottom); the slice's outer neighbours come in from the parent.
// Optional feature macro: EXECUTE_MASKSCAN_CLZ_EN (adds one_pos).
// Ports:
//   bits      in   SCAN_W  slice bits, bits[0] sits at absolute index base
//   above     in   1       bit directly above the slice (circular)
//   below     in   1       bit directly below the slice (circular)
//   base      in   5       absolute index of bits[0]
//   rise_cnt  out  6       number of run tops inside the slice
//   rise_any  out  1       at least one run top found
//   rise_pos  out  5       highest run-top position
//   stop_any  out  1       at least one run bottom found
//   stop_pos  out  5       run-bottom position
//   one_any   out  1       slice holds at least one set bit
//   one_pos   out  5       highest set bit position (clz build only)
module execute_maskscan_slice
  import execute_maskscan_pkg::*;
#(
  parameter int SCAN_W = 4
) (
  input  logic [SCAN_W-1:0] bits,
  input  logic              above,
  input  logic              below,
  input  logic [4:0]        base,
  output logic [5:0]        rise_cnt,
  output logic              rise_any,
  output logic [4:0]        rise_pos,
  output logic              stop_any,
  output logic [4:0]        stop_pos,
  output logic              one_any
`ifdef EXECUTE_MASKSCAN_CLZ_EN
  ,
  output logic [4:0]        one_pos
`endif
);

  // Neighbours are folded into one vector so every bit sees the same
  // "above" / "below" indexing: bit j of the slice lives at ext[j+1].
  logic [SCAN_W+1:0] ext;
  assign ext = {above, bits, below};

  // Walk the slice from bottom to top; later hits overwrite earlier ones,
  // so the reported positions are the highest matching bits.
  always_comb begin
    rise_cnt = '0;
    rise_any = 1'b0;
    rise_pos = '0;
    stop_any = 1'b0;
    stop_pos = '0;
    one_any  = 1'b0;
`ifdef EXECUTE_MASKSCAN_CLZ_EN
    one_pos  = '0;
`endif
    for (int j = 0; j < SCAN_W; j++) begin
      if (ext[j+1]) begin
        one_any = 1'b1;
`ifdef EXECUTE_MASKSCAN_CLZ_EN
        one_pos = base + 5'(j);
`endif
        if (!ext[j+2]) begin
          rise_cnt = rise_cnt + 6'd1;
          rise_any = 1'b1;
          rise_pos = base + 5'(j);
        end
        if (!ext[j]) begin
          stop_any = 1'b1;
          stop_pos = base + 5'(j);
        end
      end
    end
  end

endmodule

// File: rtl/execute_maskscan.sv
// execute_maskscan
// Multi-cycle decoder that decides whether a 32-bit value is a single
// circular run of ones and, if so, returns the (start_bit, stop_bit) pair
// the rotate/mask unit's mask generator needs to rebuild it. SCAN_W bits
// are examined per cycle, MSB slice first.
// Optional feature macro: EXECUTE_MASKSCAN_CLZ_EN (leading-zero count;
// when undefined clz is tied to 0).
// Ports:
//   clk        in   1   clock
//   reset      in   1   synchronous active-high reset
//   in_valid   in   1   request valid
//   in_ready   out  1   idle, can accept a request
//   in_val     in   32  value to analyse (sampled on accept only)
//   out_valid  out  1   result valid, held until out_ready
//   out_ready  in   1   consumer accepts result
//   start_bit  out  5   top bit of the run
//   stop_bit   out  5   bottom bit of the run
//   contig     out  1   value is one circular run of ones
//   is_zero    out  1   value was zero
//   clz        out  6   leading-zero count (0..32)
module execute_maskscan
  import execute_maskscan_pkg::*;
#(
  parameter int SCAN_W = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_val,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [4:0]  start_bit,
  output logic [4:0]  stop_bit,
  output logic        contig,
  output logic        is_zero,
  output logic [5:0]  clz
);

  localparam int         NSTEP     = 32 / SCAN_W;
  localparam logic [5:0] LAST_STEP = 6'(NSTEP);

  if (!scan_w_legal(SCAN_W)) begin : g_bad_scan_w
    $error("execute_maskscan: SCAN_W must be 1, 2, 4 or 8");
  end

  ms_state_e   state, state_next;

  // The value is rotated left by SCAN_W per step so the slice under
  // examination is always at the top; its wrapped upper neighbour is then
  // rot[0] and its lower neighbour rot[31-SCAN_W].
  logic [31:0] rot;
  logic [5:0]  step;
  logic [4:0]  base;
  logic [5:0]  edge_cnt;
  logic        seen_one;
  logic [4:0]  start_q;
  logic [4:0]  stop_q;

  logic [4:0]  res_start;
  logic [4:0]  res_stop;
  logic        res_contig;
  logic        res_zero;

  logic [5:0]  sl_rise_cnt;
  logic        sl_rise_any;
  logic [4:0]  sl_rise_pos;
  logic        sl_stop_any;
  logic [4:0]  sl_stop_pos;
  logic        sl_one_any;

`ifdef EXECUTE_MASKSCAN_CLZ_EN
  logic [4:0]  sl_one_pos;
  logic [4:0]  first_pos;
  logic [5:0]  res_clz;
`endif

  logic        accept;
  logic        scan_active;
  logic        finalize;

  assign accept      = in_valid && in_ready;
  assign scan_active = (state == MS_SCAN) && (step != LAST_STEP);
  // One extra SCAN cycle after the last slice folds the accumulators into
  // the result registers.
  assign finalize    = (state == MS_SCAN) && (step == LAST_STEP);

  execute_maskscan_slice #(.SCAN_W(SCAN_W)) u_slice (
    .bits     (rot[31 -: SCAN_W]),
    .above    (rot[0]),
    .below    (rot[31-SCAN_W]),
    .base     (base),
    .rise_cnt (sl_rise_cnt),
    .rise_any (sl_rise_any),
    .rise_pos (sl_rise_pos),
    .stop_any (sl_stop_any),
    .stop_pos (sl_stop_pos),
    .one_any  (sl_one_any)
`ifdef EXECUTE_MASKSCAN_CLZ_EN
    ,
    .one_pos  (sl_one_pos)
`endif
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= MS_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state)
      MS_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = MS_SCAN;
      end
      MS_SCAN: begin
        if (step == LAST_STEP) state_next = MS_DONE;
      end
      MS_DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = MS_IDLE;
      end
      default: state_next = MS_IDLE;
    endcase
  end

  // Datapath: load on accept, accumulate one slice per SCAN step, then
  // resolve the special cases (zero, all-ones) and publish the result.
  // Result registers hold their value until the next finalize or reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      rot        <= '0;
      step       <= '0;
      base       <= '0;
      edge_cnt   <= '0;
      seen_one   <= 1'b0;
      start_q    <= '0;
      stop_q     <= '0;
      res_start  <= '0;
      res_stop   <= '0;
      res_contig <= 1'b0;
      res_zero   <= 1'b0;
`ifdef EXECUTE_MASKSCAN_CLZ_EN
      first_pos  <= '0;
      res_clz    <= '0;
`endif
    end else if (accept) begin
      rot       <= in_val;
      step      <= '0;
      base      <= 5'(32 - SCAN_W);
      edge_cnt  <= '0;
      seen_one  <= 1'b0;
      start_q   <= '0;
      stop_q    <= '0;
`ifdef EXECUTE_MASKSCAN_CLZ_EN
      first_pos <= '0;
`endif
    end else if (scan_active) begin
      rot      <= {rot[31-SCAN_W:0], rot[31 -: SCAN_W]};
      step     <= step + 6'd1;
      base     <= base - 5'(SCAN_W);
      edge_cnt <= edge_cnt + sl_rise_cnt;
      if (sl_rise_any) start_q <= sl_rise_pos;
      if (sl_stop_any) stop_q  <= sl_stop_pos;
      if (sl_one_any)  seen_one <= 1'b1;
`ifdef EXECUTE_MASKSCAN_CLZ_EN
      // Slices arrive MSB first, so the first one seen is the leading one.
      if (sl_one_any && !seen_one) first_pos <= sl_one_pos;
`endif
    end else if (finalize) begin
      res_zero <= !seen_one;
      if (!seen_one) begin
        res_contig <= 1'b0;
        res_start  <= '0;
        res_stop   <= '0;
      end else if (edge_cnt == 6'd0) begin
        // Ones with no run top anywhere can only be all-ones.
        res_contig <= 1'b1;
        res_start  <= 5'd31;
        res_stop   <= 5'd0;
      end else if (edge_cnt == 6'd1) begin
        res_contig <= 1'b1;
        res_start  <= start_q;
        res_stop   <= stop_q;
      end else begin
        res_contig <= 1'b0;
        res_start  <= '0;
        res_stop   <= '0;
      end
`ifdef EXECUTE_MASKSCAN_CLZ_EN
      res_clz <= seen_one ? {1'b0, 5'd31 - first_pos} : MS_ZERO_CLZ;
`endif
    end
  end

  assign start_bit = res_start;
  assign stop_bit  = res_stop;
  assign contig    = res_contig;
  assign is_zero   = res_zero;

`ifdef EXECUTE_MASKSCAN_CLZ_EN
  assign clz = res_clz;
`else
  assign clz = 6'd0;
`endif

endmodule

// File: tb/tb_execute_maskscan.sv
// tb_execute_maskscan
// Self-checking bench for execute_maskscan. A main instance (SCAN_W=4)
// gets directed cases, handshake and reset scenarios, a full sweep of
// every (start, stop) mask and random values; three extra instances
// (SCAN_W=1, 2, 8) run random masks and values in parallel. Expected
// results come from a reference model that searches all mask pairs.
module tb_execute_maskscan;

  localparam int MAIN_W     = 4;
  localparam int MAIN_NSTEP = 32 / MAIN_W;

  logic        clk = 1'b0;
  logic        reset;
  logic        sub_reset;
  logic        sub_go = 1'b0;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_val;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  start_bit;
  logic [4:0]  stop_bit;
  logic        contig;
  logic        is_zero;
  logic [5:0]  clz;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  execute_maskscan #(.SCAN_W(MAIN_W)) u_dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_val    (in_val),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .start_bit (start_bit),
    .stop_bit  (stop_bit),
    .contig    (contig),
    .is_zero   (is_zero),
    .clz       (clz)
  );

  typedef struct packed {
    logic       contig;
    logic [4:0] start;
    logic [4:0] stop;
    logic       zero;
    logic [5:0] clz;
  } exp_t;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // The rotate/mask unit's mask: start >= stop gives bits stop..start,
  // start < stop wraps around through bit 31 / bit 0.
  function automatic logic [31:0] maskOf(input int s, input int e);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (s >= e) m[i] = (i >= e) && (i <= s);
      else        m[i] = (i >= e) || (i <= s);
    end
    return m;
  endfunction

  // Reference: a value is contiguous iff some (start, stop) pair regenerates
  // it; all-ones is reported as (31, 0), zero and multi-run values as (0, 0).
  function automatic exp_t refModel(input logic [31:0] v);
    exp_t r;
    logic found;
    r     = '0;
    r.clz = 6'd32;
    found = 1'b0;
    for (int i = 31; i >= 0; i--) begin
      if (v[i] && !found) begin
        r.clz = 6'(31 - i);
        found = 1'b1;
      end
    end
    if (v == 32'h0) begin
      r.zero = 1'b1;
    end else if (v == 32'hffff_ffff) begin
      r.contig = 1'b1;
      r.start  = 5'd31;
      r.stop   = 5'd0;
    end else begin
      for (int s = 0; s < 32; s++) begin
        for (int e = 0; e < 32; e++) begin
          if (maskOf(s, e) == v) begin
            r.contig = 1'b1;
            r.start  = 5'(s);
            r.stop   = 5'(e);
          end
        end
      end
    end
`ifndef EXECUTE_MASKSCAN_CLZ_EN
    r.clz = 6'd0;
`endif
    return r;
  endfunction

  task automatic checkResult(input string tag, input exp_t x);
    checkOutput({tag, "_contig"}, contig, x.contig);
    checkOutput({tag, "_start"}, start_bit, x.start);
    checkOutput({tag, "_stop"}, stop_bit, x.stop);
    checkOutput({tag, "_zero"}, is_zero, x.zero);
    checkOutput({tag, "_clz"}, clz, x.clz);
  endtask

  // One full transaction on the main instance: accept, latency, result,
  // optional hold with out_ready low, then handshake and return to idle.
  task automatic applyStimulus(input logic [31:0] v, input int hold);
    exp_t x;
    int   n;
    int   lat;
    x = refModel(v);
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    checkOutput("ready_before_req", in_ready, 1);
    in_val   = v;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_val   = $urandom();
    lat = 0;
    while (!out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput($sformatf("latency_%08h", v), lat, MAIN_NSTEP + 1);
    checkOutput("busy_in_ready", in_ready, 0);
    checkResult($sformatf("res_%08h", v), x);
    if (x.contig) checkOutput("regen", maskOf(int'(start_bit), int'(stop_bit)), v);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      checkOutput("hold_valid", out_valid, 1);
      checkOutput("hold_in_ready", in_ready, 0);
      checkResult("hold", x);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    checkOutput("valid_drop", out_valid, 0);
    checkOutput("ready_after", in_ready, 1);
  endtask

  // Extra instances at the other legal slice widths.
  for (genvar g = 0; g < 3; g++) begin : g_sub
    localparam int W     = (g == 0) ? 1 : ((g == 1) ? 2 : 8);
    localparam int NS    = 32 / W;
    localparam int COUNT = (g == 0) ? 40 : ((g == 1) ? 80 : 200);

    logic        iv;
    logic        ir;
    logic [31:0] vi;
    logic        ov;
    logic        ordy;
    logic [4:0]  sb;
    logic [4:0]  eb;
    logic        cg;
    logic        zr;
    logic [5:0]  cz;
    logic        done = 1'b0;

    execute_maskscan #(.SCAN_W(W)) u_sub (
      .clk       (clk),
      .reset     (sub_reset),
      .in_valid  (iv),
      .in_ready  (ir),
      .in_val    (vi),
      .out_valid (ov),
      .out_ready (ordy),
      .start_bit (sb),
      .stop_bit  (eb),
      .contig    (cg),
      .is_zero   (zr),
      .clz       (cz)
    );

    initial begin
      logic [31:0] v;
      exp_t        x;
      int          lat;
      iv   = 1'b0;
      ordy = 1'b0;
      vi   = '0;
      wait (sub_go);
      for (int t = 0; t < COUNT; t++) begin
        if (t % 4 == 3) v = $urandom();
        else            v = maskOf(int'($urandom_range(31, 0)), int'($urandom_range(31, 0)));
        x = refModel(v);
        @(negedge clk);
        checkOutput($sformatf("w%0d_ready", W), ir, 1);
        vi = v;
        iv = 1'b1;
        @(posedge clk);
        #1;
        iv = 1'b0;
        lat = 0;
        while (!ov && lat < 100) begin
          @(posedge clk);
          #1;
          lat++;
        end
        checkOutput($sformatf("w%0d_latency", W), lat, NS + 1);
        checkOutput($sformatf("w%0d_contig_%08h", W, v), cg, x.contig);
        checkOutput($sformatf("w%0d_start_%08h", W, v), sb, x.start);
        checkOutput($sformatf("w%0d_stop_%08h", W, v), eb, x.stop);
        checkOutput($sformatf("w%0d_zero", W), zr, x.zero);
        checkOutput($sformatf("w%0d_clz", W), cz, x.clz);
        ordy = 1'b1;
        @(posedge clk);
        #1;
        ordy = 1'b0;
      end
      done = 1'b1;
    end
  end

  initial begin
    int   n;
    logic rose;
    exp_t x;

    reset     = 1'b1;
    sub_reset = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_val    = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_start", start_bit, 0);
    checkOutput("rst_stop", stop_bit, 0);
    checkOutput("rst_contig", contig, 0);
    checkOutput("rst_zero", is_zero, 0);
    checkOutput("rst_clz", clz, 0);
    reset     = 1'b0;
    sub_reset = 1'b0;
    sub_go    = 1'b1;

    // Directed cases, including wrapped runs, all-ones, zero and two runs.
    applyStimulus(32'h0003_fffe, 0);
    applyStimulus(32'h8000_0001, 0);
    applyStimulus(32'hff00_00ff, 0);
    applyStimulus(32'hffff_ffff, 0);
    applyStimulus(32'h0000_0000, 0);
    applyStimulus(32'h00f0_00f0, 0);
    applyStimulus(32'h0ff0_0000, 5);
    applyStimulus(32'h0000_0001, 2);
    applyStimulus(32'h8000_0000, 0);
    applyStimulus(32'h7fff_ffff, 0);

    // Reset during SCAN: the result is discarded and never presented.
    @(negedge clk);
    in_val   = 32'h00ff_0000;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_scan_in_ready", in_ready, 1);
    checkOutput("rst_scan_valid", out_valid, 0);
    rose = 1'b0;
    for (int c = 0; c < 2 * MAIN_NSTEP; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) rose = 1'b1;
    end
    checkOutput("rst_scan_no_valid", rose, 0);
    checkOutput("rst_scan_idle", in_ready, 1);

    // Reset while DONE: out_valid drops and outputs return to reset values.
    @(negedge clk);
    in_val   = 32'h0000_ff00;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    checkOutput("rst_done_reached", out_valid, 1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("rst_done_valid", out_valid, 0);
    checkOutput("rst_done_in_ready", in_ready, 1);
    checkOutput("rst_done_contig", contig, 0);

    // Every (start, stop) pair must decode back to a mask that regenerates it.
    for (int s = 0; s < 32; s++) begin
      for (int e = 0; e < 32; e++) begin
        applyStimulus(maskOf(s, e), 0);
      end
    end

    // Random values and random masks with random consumer stalls.
    for (int t = 0; t < 150; t++) begin
      if (t % 2 == 0) applyStimulus($urandom(), int'($urandom_range(3, 0)));
      else applyStimulus(maskOf(int'($urandom_range(31, 0)), int'($urandom_range(31, 0))),
                         int'($urandom_range(3, 0)));
    end

    n = 0;
    while (!(g_sub[0].done && g_sub[1].done && g_sub[2].done) && n < 20000) begin
      @(posedge clk);
      n++;
    end
    checkOutput("sub_done", {31'd0, g_sub[0].done && g_sub[1].done && g_sub[2].done}, 1);

    x = refModel(32'h0003_fffe);
    checkOutput("model_sanity_start", x.start, 17);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
